ray_cast_sequencer: RTL and testbench

- Initiator for the ray-cast register block: drives its two write ports (a/a_en/control_a, b/b_en/control_b) and reads back ray_distance/uv_x.
- For one ray, loads player position and ray direction once, then streams every wall from wall memory through the intersector.
- Keeps the nearest hit; reports distance, UV and wall index to the column renderer / distance buffer with a done pulse.

---
 rtl/ray_cast_sequencer_pkg.sv | 28 ++
 rtl/ray_cast_wall_fetch.sv | 57 +++++
 rtl/ray_cast_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ray_cast_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ray_cast_sequencer_pkg.sv
// Shared definitions for the ray-cast sequencer and the ray-cast register block:
// register-select codes, the miss distance and the sequencer state encoding.
package ray_cast_sequencer_pkg;

  typedef enum logic [2:0] {
    CTRL_PLAYER_POS = 3'b000,
    CTRL_RAY_DIR    = 3'b001,
    CTRL_WALL_START = 3'b010,
    CTRL_WALL_END   = 3'b011,
    CTRL_WALL_PTR   = 3'b100
  } ctrl_e;

  localparam logic [15:0] DIST_MISS = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_PLAYER,
    S_LOAD_RAY,
    S_FETCH,
    S_FETCH_LAST,
    S_LOAD_START,
    S_LOAD_END,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_e;

endpackage

// File: rtl/ray_cast_wall_fetch.sv
// Wall fetcher: walks the four words (x1, y1, x2, y2) of wall wall_idx and
// captures each one the cycle after it is read, because memory has one cycle of read latency.
module ray_cast_wall_fetch
  import ray_cast_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WALL_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch,
  input  logic [ADDR_W-1:0] wall_base,
  input  logic [WALL_W-1:0] wall_idx,
  input  logic [15:0]       wall_rd_data,
  output logic              wall_rd_en,
  output logic [ADDR_W-1:0] wall_addr,
  output logic              last_word,
  output logic [15:0]       x1,
  output logic [15:0]       y1,
  output logic [15:0]       x2,
  output logic [15:0]       y2
);

  logic [1:0]        word_sel;
  logic [1:0]        cap_sel;
  logic              cap_en;
  logic [15:0]       word_q [4];
  logic [ADDR_W-1:0] wall_offset;

  // Four words per wall; the address wraps modulo 2**ADDR_W.
  assign wall_offset = ADDR_W'({wall_idx, 2'b00});
  assign wall_rd_en  = fetch;
  assign wall_addr   = fetch ? wall_base + wall_offset + ADDR_W'(word_sel) : '0;
  assign last_word   = fetch && (word_sel == 2'd3);

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // the tiny word store is reset too, so x1..y2 never leak X into the register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_sel <= '0;
      cap_sel  <= '0;
      cap_en   <= 1'b0;
      for (int w = 0; w < 4; w++) word_q[w] <= '0;
    end else begin
      word_sel <= fetch ? word_sel + 2'd1 : 2'd0;
      cap_en   <= fetch;
      cap_sel  <= word_sel;
      if (cap_en) word_q[cap_sel] <= wall_rd_data;
    end
  end

  assign x1 = word_q[0];
  assign y1 = word_q[1];
  assign x2 = word_q[2];
  assign y2 = word_q[3];

endmodule

// File: rtl/ray_cast_sequencer.sv
// Ray-cast sequencer: loads player/ray, streams every wall through the intersector
// and keeps the nearest hit. Optional near clip: define RAY_CAST_SEQ_NEAR_CLIP_EN.
module ray_cast_sequencer
  import ray_cast_sequencer_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WALL_W      = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] NEAR_CLIP   = 16'h0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       player_x,
  input  logic [15:0]       player_y,
  input  logic [15:0]       ray_dx,
  input  logic [15:0]       ray_dy,
  input  logic [ADDR_W-1:0] wall_base,
  input  logic [WALL_W-1:0] wall_count,
  output logic              wall_rd_en,
  output logic [ADDR_W-1:0] wall_addr,
  input  logic [15:0]       wall_rd_data,
  output logic              a_en,
  output logic              b_en,
  output logic [15:0]       a,
  output logic [15:0]       b,
  output logic [2:0]        control_a,
  output logic [2:0]        control_b,
  input  logic [15:0]       ray_distance,
  input  logic [15:0]       uv_x,
  output logic              busy,
  output logic              done,
  output logic [15:0]       best_distance,
  output logic [15:0]       best_uv,
  output logic [WALL_W-1:0] best_wall,
  output logic              hit
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [15:0]       px_q, py_q, dx_q, dy_q;
  logic [ADDR_W-1:0] base_q;
  logic [WALL_W-1:0] count_q, idx_q;
  logic [WAIT_W-1:0] wait_q;
  logic              last_word, last_wall, near_ok, accept;
  logic [15:0]       x1, y1, x2, y2;
  ctrl_e             ctrl;

  ray_cast_wall_fetch #(.ADDR_W(ADDR_W), .WALL_W(WALL_W)) u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (state_q == S_FETCH),
    .wall_base    (base_q),
    .wall_idx     (idx_q),
    .wall_rd_data (wall_rd_data),
    .wall_rd_en   (wall_rd_en),
    .wall_addr    (wall_addr),
    .last_word    (last_word),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2)
  );

  // One extra bit so wall_count == 255 terminates before the index could wrap.
  assign last_wall = ({1'b0, idx_q} + (WALL_W+1)'(1)) == {1'b0, count_q};

`ifdef RAY_CAST_SEQ_NEAR_CLIP_EN
  assign near_ok = ray_distance >= NEAR_CLIP;
`else
  assign near_ok = 1'b1;
`endif

  // Strict less-than keeps the earlier wall on equal distances.
  assign accept = (ray_distance != DIST_MISS) && (ray_distance < best_distance) && near_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (start) state_d = S_LOAD_PLAYER;
      S_LOAD_PLAYER: state_d = S_LOAD_RAY;
      S_LOAD_RAY:    state_d = (count_q == '0) ? S_DONE : S_FETCH;
      S_FETCH:       if (last_word) state_d = S_FETCH_LAST;
      S_FETCH_LAST:  state_d = S_LOAD_START;
      S_LOAD_START:  state_d = S_LOAD_END;
      S_LOAD_END:    state_d = S_WAIT;
      S_WAIT:        if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) state_d = S_COMPARE;
      S_COMPARE:     state_d = last_wall ? S_DONE : S_FETCH;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl = CTRL_PLAYER_POS;
    a_en = 1'b0;
    a    = '0;
    b    = '0;
    unique case (state_q)
      S_LOAD_PLAYER: begin a_en = 1'b1; a = px_q; b = py_q; end
      S_LOAD_RAY:    begin a_en = 1'b1; ctrl = CTRL_RAY_DIR;    a = dx_q; b = dy_q; end
      S_LOAD_START:  begin a_en = 1'b1; ctrl = CTRL_WALL_START; a = x1;   b = y1;   end
      S_LOAD_END:    begin a_en = 1'b1; ctrl = CTRL_WALL_END;   a = x2;   b = y2;   end
      default: ;
    endcase
  end

  assign b_en      = a_en;
  assign control_a = ctrl;
  assign control_b = ctrl;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q          <= '0;
      py_q          <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      base_q        <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      wait_q        <= '0;
      best_distance <= DIST_MISS;
      best_uv       <= '0;
      best_wall     <= '0;
      hit           <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          px_q          <= player_x;
          py_q          <= player_y;
          dx_q          <= ray_dx;
          dy_q          <= ray_dy;
          base_q        <= wall_base;
          count_q       <= wall_count;
          idx_q         <= '0;
          best_distance <= DIST_MISS;
          best_uv       <= '0;
          best_wall     <= '0;
          hit           <= 1'b0;
        end
        S_LOAD_END: wait_q <= '0;
        S_WAIT:     wait_q <= wait_q + WAIT_W'(1);
        S_COMPARE: begin
          if (accept) begin
            best_distance <= ray_distance;
            best_uv       <= uv_x;
            best_wall     <= idx_q;
            hit           <= 1'b1;
          end
          idx_q <= idx_q + WALL_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_cast_sequencer.sv
// Self-checking bench for ray_cast_sequencer: wall memory, a behavioural intersector
// responder and a nearest-hit reference model, driven by directed and random rays.
module tb_ray_cast_sequencer;
  localparam int          ADDR_W      = 10;
  localparam int          WALL_W      = 8;
  localparam int          WAIT_CYCLES = 2;
  localparam logic [15:0] NEAR_CLIP   = 16'h0010;
  localparam int          PER_WALL    = 8 + WAIT_CYCLES;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0]       player_x = '0, player_y = '0, ray_dx = '0, ray_dy = '0;
  logic [ADDR_W-1:0] wall_base = '0;
  logic [WALL_W-1:0] wall_count = '0;
  logic              wall_rd_en, a_en, b_en, busy, done, hit;
  logic [ADDR_W-1:0] wall_addr;
  logic [15:0]       wall_rd_data = '0, ray_distance = '0, uv_x = '0;
  logic [15:0]       a, b, best_distance, best_uv;
  logic [2:0]        control_a, control_b;
  logic [WALL_W-1:0] best_wall;

  ray_cast_sequencer #(.ADDR_W(ADDR_W), .WALL_W(WALL_W), .WAIT_CYCLES(WAIT_CYCLES),
                       .NEAR_CLIP(NEAR_CLIP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .player_x(player_x), .player_y(player_y), .ray_dx(ray_dx), .ray_dy(ray_dy),
    .wall_base(wall_base), .wall_count(wall_count),
    .wall_rd_en(wall_rd_en), .wall_addr(wall_addr), .wall_rd_data(wall_rd_data),
    .a_en(a_en), .b_en(b_en), .a(a), .b(b), .control_a(control_a), .control_b(control_b),
    .ray_distance(ray_distance), .uv_x(uv_x), .busy(busy), .done(done),
    .best_distance(best_distance), .best_uv(best_uv), .best_wall(best_wall), .hit(hit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ca;
    logic [2:0]  cb;
    logic        ae;
    logic        be;
    logic [15:0] wa;
    logic [15:0] wb;
  } load_t;

  int                tests_run = 0, tests_failed = 0;
  logic [15:0]       mem [1024];
  logic [15:0]       dist_tab [256];
  logic [15:0]       uv_tab [256];
  load_t             load_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  logic [WALL_W-1:0] resp_idx = '0, resp_sel = '0;
  int                resp_wait = 0;

  // Wall memory: data valid the cycle after the read strobe.
  always @(posedge clk) if (wall_rd_en) wall_rd_data <= mem[wall_addr];

  // Intersector: garbage right after the wall-end load, the real answer WAIT_CYCLES later.
  always @(posedge clk) begin
    if (start && !busy) resp_idx <= '0;
    if (b_en && control_b == 3'b011) begin
      ray_distance <= 16'h0001;
      uv_x         <= 16'hDEAD;
      resp_sel     <= resp_idx;
      resp_idx     <= resp_idx + 1'b1;
      resp_wait    <= WAIT_CYCLES;
    end else if (resp_wait > 1) begin
      resp_wait <= resp_wait - 1;
    end else if (resp_wait == 1) begin
      ray_distance <= dist_tab[resp_sel];
      uv_x         <= uv_tab[resp_sel];
      resp_wait    <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nearest accepted hit, straight from the acceptance rule.
  task automatic model_best(input int n, output logic [15:0] bd, output logic [15:0] bu,
                            output logic [WALL_W-1:0] bw, output logic h);
    logic ok;
    bd = 16'hFFFF; bu = '0; bw = '0; h = 1'b0;
    for (int i = 0; i < n; i++) begin
      ok = (dist_tab[i] != 16'hFFFF) && (dist_tab[i] < bd);
`ifdef RAY_CAST_SEQ_NEAR_CLIP_EN
      if (dist_tab[i] < NEAR_CLIP) ok = 1'b0;
`endif
      if (ok) begin bd = dist_tab[i]; bu = uv_tab[i]; bw = WALL_W'(i); h = 1'b1; end
    end
  endtask

  task automatic run_ray(input string tag, input logic [15:0] px, input logic [15:0] py,
                         input logic [15:0] dx, input logic [15:0] dy,
                         input logic [ADDR_W-1:0] base, input int n, input int restart_at);
    logic [15:0] bd, bu; logic [WALL_W-1:0] bw; logic h;
    load_t exp_q [$];
    int c, done_at, idle_cycles, waddr;
    load_q.delete(); addr_q.delete();
    done_at = -1; idle_cycles = 0;
    @(negedge clk);
    player_x = px; player_y = py; ray_dx = dx; ray_dy = dy;
    wall_base = base; wall_count = WALL_W'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    player_x = ~px; player_y = ~py; ray_dx = ~dx; ray_dy = ~dy;
    wall_base = ~base; wall_count = ~WALL_W'(n);
    c = 1;
    while (c < 3 + n * PER_WALL + 20) begin
      if (!busy) idle_cycles++;
      if (wall_rd_en) addr_q.push_back(wall_addr);
      if (a_en || b_en) load_q.push_back('{control_a, control_b, a_en, b_en, a, b});
      if (done) begin done_at = c; break; end
      start = (c == restart_at);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 64'(done_at), 64'(3 + n * PER_WALL));
    check({tag, " busy_gaps"}, 64'(idle_cycles), 64'd0);
    model_best(n, bd, bu, bw, h);
    check({tag, " best_distance"}, 64'(best_distance), 64'(bd));
    check({tag, " best_uv"}, 64'(best_uv), 64'(bu));
    check({tag, " best_wall"}, 64'(best_wall), 64'(bw));
    check({tag, " hit"}, 64'(hit), 64'(h));
    exp_q.push_back('{3'b000, 3'b000, 1'b1, 1'b1, px, py});
    exp_q.push_back('{3'b001, 3'b001, 1'b1, 1'b1, dx, dy});
    for (int i = 0; i < n; i++) begin
      waddr = int'(base) + 4 * i;
      exp_q.push_back('{3'b010, 3'b010, 1'b1, 1'b1, mem[waddr % 1024], mem[(waddr + 1) % 1024]});
      exp_q.push_back('{3'b011, 3'b011, 1'b1, 1'b1, mem[(waddr + 2) % 1024], mem[(waddr + 3) % 1024]});
    end
    check({tag, " load_count"}, 64'(load_q.size()), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < load_q.size(); j++)
      check($sformatf("%s load%0d", tag, j), 64'(load_q[j]), 64'(exp_q[j]));
    check({tag, " read_count"}, 64'(addr_q.size()), 64'(4 * n));
    for (int j = 0; j < 4 * n && j < addr_q.size(); j++)
      check($sformatf("%s addr%0d", tag, j), 64'(addr_q[j]), 64'((int'(base) + j) % 1024));
    @(negedge clk);
    check({tag, " done_pulse_width"}, 64'({done, busy}), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " flags"}, 64'({busy, done, hit, a_en, b_en, wall_rd_en}), 64'd0);
    check({tag, " best_distance"}, 64'(best_distance), 64'hFFFF);
    check({tag, " best_uv_wall"}, 64'({best_uv, best_wall}), 64'd0);
    check({tag, " a_b"}, 64'({a, b}), 64'd0);
    check({tag, " control_addr"}, 64'({control_a, control_b, wall_addr}), 64'd0);
  endtask

  initial begin
    int c, done_seen, n;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) begin dist_tab[i] = 16'hFFFF; uv_tab[i] = 16'h00A0 + 16'(i); end

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    run_ray("empty", 16'h1234, 16'h5678, 16'h0100, 16'hFF00, 10'h020, 0, -1);

    dist_tab[0] = 16'h0300; dist_tab[1] = 16'h0180; dist_tab[2] = 16'hFFFF;
    run_ray("three", 16'h0A00, 16'h0B00, 16'h00B5, 16'h00B5, 10'h040, 3, -1);

    dist_tab[0] = 16'h0123;
    run_ray("wrap", 16'h0101, 16'h0202, 16'h0303, 16'h0404, 10'h3FE, 1, -1);

    dist_tab[0] = 16'h0200; dist_tab[1] = 16'h0200;
    run_ray("tie_restart", 16'h0C00, 16'h0D00, 16'h0010, 16'h0020, 10'h100, 2, 5);

    dist_tab[0] = 16'h0008; dist_tab[1] = 16'h0400;
    run_ray("near_clip", 16'h0E00, 16'h0F00, 16'h0040, 16'h0000, 10'h200, 2, -1);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        dist_tab[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
        uv_tab[i]   = 16'($urandom);
      end
      run_ray($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), ADDR_W'($urandom), n, $urandom_range(0, 1) ? 7 : -1);
    end

    // Abort during the WAIT of wall 1, after wall 0 has already been accepted.
    dist_tab[0] = 16'h0100; dist_tab[1] = 16'h0080; dist_tab[2] = 16'h0040;
    @(negedge clk);
    wall_base = 10'h080; wall_count = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (c < 3 + PER_WALL + 7) begin @(negedge clk); c++; end
    check("abort pre_state", 64'({busy, best_distance}), 64'h1_0100);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    done_seen = 0;
    repeat (4) begin @(negedge clk); if (done) done_seen++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done) done_seen++; end
    check("abort no_done", 64'(done_seen), 64'd0);
    run_ray("after_abort", 16'h1111, 16'h2222, 16'h3333, 16'h4444, 10'h080, 3, -1);

    for (int i = 0; i < 255; i++) dist_tab[i] = 16'hF000 - 16'(i * 16);
    run_ray("count255", 16'h0500, 16'h0600, 16'h0001, 16'h0002, 10'h000, 255, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
